// File: rtl/mc_mem_responder_pkg.sv
// mc_mem_responder_pkg: shared memory-system constants used by the cpu, caches and memory responder
//   ADDR_W       byte address width
//   DATA_W       word width
//   MEM_LATENCY  issue-edge to data_valid latency in cycles
package mc_mem_responder_pkg;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int MEM_LATENCY = 4;
    localparam int PEND_W      = 3;
endpackage

// File: rtl/mc_mem_responder_if.sv
// mc_mem_responder_if: request/response bus between a cache and main memory
//   enable, wr, addr, data_in    request, driven by the master (cache side)
//   data_out, data_valid         read response, driven by the slave (memory side)
//   pending                      reads in flight, debug only
interface mc_mem_responder_if;
    import mc_mem_responder_pkg::*;
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [PEND_W-1:0] pending;
    modport master (output enable, wr, addr, data_in, input data_out, data_valid, pending);
    modport slave  (input enable, wr, addr, data_in, output data_out, data_valid, pending);
endinterface

// File: rtl/mc_mem_responder_delay_line.sv
// mem_delay_line: DEPTH-stage valid+data shift register with asynchronous active-low reset
//   clk, rst_n   clock and async reset (clears every stage)
//   in_valid     valid bit loaded into stage 0 each edge
//   in_data      data loaded into stage 0 each edge
//   out_valid    valid bit of the last stage
//   out_data     data of the last stage, forced to 0 when out_valid=0
module mem_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            v    <= {v[DEPTH-2:0], in_valid};
            d[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) d[i] <= d[i-1];
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = v[DEPTH-1] ? d[DEPTH-1] : '0;
endmodule

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: fully pipelined fixed-latency main-memory responder for cache refills and write-throughs
//   clk, rst_n   clock and async active-low reset (pipeline and pending cleared, array kept)
//   bus.slave    enable/wr/addr/data_in requests in; data_out/data_valid/pending out
module mc_mem_responder
    import mc_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 2 ** (ADDR_W - 1),
    parameter int LATENCY   = MEM_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    mc_mem_responder_if.slave   bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              rd_acc;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [PEND_W-1:0] pending;

    // byte address -> word index, wrapped onto the array (odd bytes alias the even word)
    assign idx    = IDX_W'(32'(bus.addr[ADDR_W-1:1]) % MEM_WORDS);
    assign rd_acc = bus.enable && !bus.wr;

    always_ff @(posedge clk)
        if (bus.enable && bus.wr) mem[idx] <= bus.data_in;

    // stage 0 captures the pre-write array word, so in-flight reads keep old data
    mem_delay_line #(.DEPTH(LATENCY), .WIDTH(DATA_W)) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc),
        .in_data   (mem[idx]),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pending <= '0;
        else        pending <= pending + PEND_W'(rd_acc) - PEND_W'(out_valid);

    assign bus.data_valid = out_valid;
    assign bus.data_out   = out_data;
    assign bus.pending    = pending;
endmodule
